// File: rtl/led_matrix_scan_if.sv
// Frame/panel bundle between the physics block, this scanner and the
// board pins. The slave modport is the scanner; the master side supplies
// the frame and blank control and observes the panel pins.
interface led_matrix_scan_if;
  logic [255:0] matrix;      // bit y*16+x = pixel (x,y), 1 = lit
  logic         blank;       // 1 = keep panel dark, timing unaffected
  logic         sclk;        // column shift clock, panel samples on rise
  logic         sdata;       // column serial data
  logic         latch;       // transfer shifted columns to driver outputs
  logic         oe_n;        // active-low panel output enable
  logic [3:0]   row_sel;     // row decoder select
  logic         frame_done;  // pulse on the last display cycle of row 15

  modport master (
    output matrix, blank,
    input  sclk, sdata, latch, oe_n, row_sel, frame_done
  );

  modport slave (
    input  matrix, blank,
    output sclk, sdata, latch, oe_n, row_sel, frame_done
  );
endinterface

// File: rtl/led_matrix_scan.sv
// 16x16 LED panel row scanner. Captures the whole frame into a shadow
// buffer at the start of every frame (row 0 LOAD) so the picture never
// tears, then per row: shifts 16 column bits out MSB (x=15) first, pulses
// latch while switching the row decoder, and holds the row lit.
module led_matrix_scan #(
  parameter int CLK_DIV     = 2,     // clk cycles per sclk phase, >=1
  parameter int HOLD_CYCLES = 1000   // clk cycles a row stays lit, >=1
) (
  input  logic             clk,
  input  logic             reset,
  led_matrix_scan_if.slave bus
);

  localparam int PH_MAX = 2 * CLK_DIV - 1;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int HC_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_LATCH, S_DISP} state_t;

  state_t            state_q;
  logic [255:0]      shadow_q;
  logic [3:0]        row_q;
  logic [15:0]       shreg_q;     // MSB is the bit currently on sdata
  logic [3:0]        bit_q;       // remaining bits in the row, 15..0
  logic [PH_W-1:0]   ph_q;        // position inside one sclk period
  logic [HC_W-1:0]   hc_q;        // display hold counter
  logic              sclk_q;
  logic              latch_q;
  logic              disp_q;      // row is in its display window
  logic [3:0]        row_sel_q;
  logic              fdone_q;
  logic [15:0]       load_row_d;

  // Row to load: row 0 comes straight from the incoming frame because the
  // shadow is being refreshed in that same cycle.
  always_comb begin
    load_row_d = shadow_q[int'(row_q) * 16 +: 16];
    if (row_q == 4'd0) load_row_d = bus.matrix[15:0];
  end

  // Scan FSM; all panel outputs are registered alongside the state so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LOAD;
      shadow_q  <= '0;
      row_q     <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      ph_q      <= '0;
      hc_q      <= '0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      disp_q    <= 1'b0;
      row_sel_q <= '0;
      fdone_q   <= 1'b0;
    end else begin
      latch_q <= 1'b0;
      fdone_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (row_q == 4'd0) shadow_q <= bus.matrix;
          shreg_q <= load_row_d;
          bit_q   <= 4'd15;
          ph_q    <= '0;
          sclk_q  <= 1'b0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (ph_q == PH_W'(PH_MAX)) begin
            // end of one bit period: sclk low again, move to next column
            ph_q   <= '0;
            sclk_q <= 1'b0;
            if (bit_q == 4'd0) begin
              latch_q   <= 1'b1;
              row_sel_q <= row_q;
              state_q   <= S_LATCH;
            end else begin
              bit_q   <= bit_q - 4'd1;
              shreg_q <= {shreg_q[14:0], 1'b0};
            end
          end else begin
            ph_q   <= ph_q + 1'b1;
            // second half of the bit period drives sclk high
            sclk_q <= (ph_q >= PH_W'(CLK_DIV - 1));
          end
        end
        S_LATCH: begin
          disp_q  <= 1'b1;
          hc_q    <= '0;
          fdone_q <= (HOLD_CYCLES == 1) && (row_q == 4'd15);
          state_q <= S_DISP;
        end
        S_DISP: begin
          if (hc_q == HC_W'(HOLD_CYCLES - 1)) begin
            disp_q  <= 1'b0;
            row_q   <= row_q + 4'd1;
            state_q <= S_LOAD;
          end else begin
            hc_q    <= hc_q + 1'b1;
            // raise frame_done for the final display cycle of row 15
            fdone_q <= (hc_q == HC_W'(HOLD_CYCLES - 2)) && (row_q == 4'd15);
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.sdata      = shreg_q[15];
  assign bus.latch      = latch_q;
  assign bus.oe_n       = ~disp_q | bus.blank;
  assign bus.row_sel    = row_sel_q;
  assign bus.frame_done = fdone_q;

endmodule
